// File: rtl/async_fifo_wr_arbiter_if.sv
// Bundle between NREQ write requesters, the async FIFO write port and the
// round-robin write arbiter that shares that port.
interface async_fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
);
    localparam int IDW = $clog2(NREQ);

    // A requester beat moves on a clk edge where req_valid[i] && req_ready[i];
    // ready never depends on anything but grant and wfull, and a FIFO word is
    // written exactly when winc is high, which never happens while wfull is high.
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  winc;
    logic [IDW+DSIZE-1:0]  wdata;
    logic                  wfull;
    logic                  state_dbg;

    // Requesters plus FIFO side.
    modport master (
        output req_valid, req_data, req_last, wfull,
        input  req_ready, grant, busy, winc, wdata, state_dbg
    );

    // The arbiter.
    modport slave (
        input  req_valid, req_data, req_last, wfull,
        output req_ready, grant, busy, winc, wdata, state_dbg
    );
endinterface

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin burst arbiter for the write port of an async FIFO; every word is
// tagged with the index of the requester that produced it.
module async_fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBURST = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    async_fifo_wr_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAXBURST + 1);
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);
    localparam logic [CW-1:0]  CNT_CAP  = CW'(MAXBURST - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  owner;
    logic [IDW-1:0]  owner_nxt;
    logic [IDW-1:0]  last_ptr;
    logic [IDW-1:0]  last_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] grant_nxt;

    logic            win_found;
    logic [IDW-1:0]  win_idx;
    int              scan_idx;

    logic            owner_valid;
    logic            owner_last;
    logic [DSIZE-1:0] owner_data;
    logic            xfer;
    logic            burst_end;

    // Scan last+1, last+2, ... so the previous owner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = int'(last_ptr) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!win_found && bus.req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(scan_idx);
            end
        end
    end

    assign owner_valid = bus.req_valid[owner];
    assign owner_last  = bus.req_last[owner];
    assign owner_data  = bus.req_data[owner*DSIZE +: DSIZE];

    assign xfer      = (state == S_BURST) && owner_valid && !bus.wfull;
    assign burst_end = xfer && (owner_last || (cnt == CNT_CAP));

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last_ptr;
        cnt_nxt   = cnt;
        grant_nxt = grant_q;
        case (state)
            S_IDLE: begin
                if (win_found && !bus.wfull) begin
                    state_nxt = S_BURST;
                    owner_nxt = win_idx;
                    grant_nxt = NREQ'(1) << win_idx;
                    cnt_nxt   = '0;
                end
            end
            S_BURST: begin
                // wfull or a bubble leaves everything frozen; only transfers advance.
                if (burst_end) begin
                    state_nxt = S_IDLE;
                    grant_nxt = '0;
                    last_nxt  = owner;
                    cnt_nxt   = '0;
                end else if (xfer) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            owner    <= '0;
            last_ptr <= LAST_RST;
            cnt      <= '0;
            grant_q  <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last_ptr <= last_nxt;
            cnt      <= cnt_nxt;
            grant_q  <= grant_nxt;
        end
    end

    // Outputs decode from registered state only, so reset drops them at once.
    assign bus.grant     = grant_q;
    assign bus.busy      = (state == S_BURST);
    assign bus.req_ready = ((state == S_BURST) && !bus.wfull) ? grant_q : '0;
    assign bus.winc      = xfer;
    assign bus.wdata     = (state == S_BURST) ? {owner, owner_data} : '0;
    assign bus.state_dbg = state;

    assert property (@(posedge clk) disable iff (rst) !(bus.winc && bus.wfull));
    assert property (@(posedge clk) disable iff (rst) $onehot0(bus.grant));
    assert property (@(posedge clk) disable iff (rst) (bus.req_ready & ~bus.grant) == '0);
    assert property (@(posedge clk) disable iff (rst) bus.busy == (bus.grant != '0));

endmodule

// File: doc/async_fifo_wr_arbiter.md
Name: async_fifo_wr_arbiter

Overview:
- Write-side scheduler that shares the single write port of an async_fifo instance among NREQ requesters.
- Sits entirely in the FIFO write clock domain. Grants the port round-robin in bursts, with a beat cap per burst.
- Each written word is tagged with the source index so the read side can demultiplex.
- Drives winc/wdata and honours wfull, so no beat is ever lost or duplicated.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DSIZE, 8, payload width per requester.
- IDW, $clog2(NREQ), tag width. Derived; do not override.
- MAXBURST, 16, maximum beats per grant (1..255).

Ports:
- clk  in  1  write-domain clock; the same clock as the FIFO wclk.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester beat valid.
- req_data  in  NREQ*DSIZE  per-requester payload; requester i occupies bits [i*DSIZE +: DSIZE].
- req_last  in  NREQ  marks the final beat of a requester's packet.
- req_ready  out  NREQ  per-requester beat accept.
- grant  out  NREQ  one-hot current owner; all zero when idle.
- busy  out  1  high while in the BURST state.
- winc  out  1  FIFO write enable.
- wdata  out  IDW+DSIZE  FIFO write word, {owner index, payload}.
- wfull  in  1  FIFO full flag.

Behaviour:
- Reset (asynchronous, takes effect immediately on rst rising):
  - state=IDLE; grant=0; busy=0; req_ready=0; winc=0; wdata=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - Beat counter cnt=0.
- State IDLE:
  - req_ready=0 and winc=0.
  - If any req_valid is high and wfull=0, pick the winner: the first requester with valid set, scanning last+1, last+2, ... modulo NREQ.
  - At the next clk edge: grant<=onehot(winner), owner<=winner, cnt<=0, state<=BURST.
  - Otherwise stay in IDLE.
  - Arbitration latency is 1 cycle; no data moves in IDLE.
- State BURST, owner g:
  - req_ready[g] = !wfull. All other req_ready bits are 0.
  - winc = req_valid[g] & !wfull (combinational).
  - wdata = {g, req_data[g]} (combinational). wdata is don't-care when winc=0, but holds a defined value.
  - A transfer occurs when winc=1. On each transfer, cnt<=cnt+1.
  - End of burst is a transfer where req_last[g]=1 or cnt==MAXBURST-1. At the next edge: state<=IDLE, grant<=0, last<=g, cnt<=0.
  - req_valid[g] low mid-burst: the grant is held and bubbles are allowed. There is no timeout.
  - wfull high mid-burst: winc=0 and req_ready[g]=0. The grant, cnt and state are frozen until wfull falls.
  - Because of the IDLE turnaround, at least one bubble cycle separates consecutive bursts.
- Fairness:
  - After a burst from g, g has the lowest priority at the next arbitration.
  - A single continuously-requesting source re-wins after one IDLE cycle.
- Widths:
  - cnt is $clog2(MAXBURST+1) bits.
  - The tag is an unsigned owner index, zero-extended to IDW.
- Simultaneous events:
  - A new request arriving in the same cycle as end of burst is considered in the following IDLE cycle.
  - req_last together with the MAXBURST cap is a single end of burst.
- Reset mid-burst: the burst is abandoned immediately. No winc is asserted after rst rises. The next burst after reset starts from requester 0's priority.
- Protocol invariants:
  - winc=1 never coincides with wfull=1.
  - grant is always one-hot or zero.
  - req_ready[i]=1 implies grant[i]=1.

Test Plan:
1. Reset, then requester 1 sends 3 beats 0xA1,0xA2,0xA3 (last on the third), wfull=0.
   - Required: grant=0010 one cycle after valid.
   - Required: winc for 3 cycles with wdata=0x1A1,0x1A2,0x1A3 (IDW=2).
   - Required: grant=0 on the next cycle.
2. Requesters 0 and 2 both hold valid with 1-beat packets.
   - Required: grant order is 0,2,0,2.
   - Required: each burst is followed by one IDLE cycle.
3. MAXBURST=4; requester 3 streams 10 beats with no last.
   - Required: bursts of 4,4,2 beats, split by IDLE cycles.
   - Required: other requesters with valid win between these bursts.
4. Raise wfull for 5 cycles mid-burst after beat 2 of 6.
   - Required: winc=0 and req_ready=0 during those cycles; grant is held.
   - Required: beats 3-6 resume in order with no loss or duplication.
   - Check: a scoreboard tag/payload compare after the async_fifo read side.
5. Assert rst for 1 cycle while requester 2 is mid-burst.
   - Required: grant, winc and req_ready drop asynchronously.
   - Required: after release, with requesters 2 and 0 valid, requester 0 is granted first.
6. Random valid/last/wfull for 10k cycles against the async_fifo.
   - Required: per-source ordering is preserved.
   - Required: the invariants from Behaviour hold every cycle.
